// File: rtl/mul_pkg.sv
// mul_pkg: shared types, defaults and sizing helper for the multicycle HI/LO multiply unit.
package mul_pkg;
    typedef enum logic {IDLE, BUSY} state_e;
    localparam int MUL_W_DEFAULT   = 32;
    localparam int MUL_CYC_DEFAULT = 4;
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/mul_hilo_unit_boothmul.sv
// boothmul: combinational radix-2 Booth signed multiplier, full 2*DATA_WIDTH product.
module boothmul #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   q_i,
    input  logic [DATA_WIDTH-1:0]   m_i,
    output logic [2*DATA_WIDTH-1:0] p_o
);
    logic [2*DATA_WIDTH-1:0] qx;
    logic [DATA_WIDTH:0]     mx;
    assign qx = {{DATA_WIDTH{q_i[DATA_WIDTH-1]}}, q_i};
    assign mx = {m_i, 1'b0};
    // Each bit pair {m[i], m[i-1]} selects +Q, -Q or nothing at weight 2^i.
    always_comb begin
        p_o = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (mx[i+1] && !mx[i]) p_o = p_o - (qx << i);
            if (!mx[i+1] && mx[i]) p_o = p_o + (qx << i);
        end
    end
endmodule

// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit: holds operands for MUL_CYCLES clocks around boothmul, then captures HI/LO.
// Optional MUL_OVF_EN adds an ovf flag set when the product does not fit in DATA_WIDTH.
module mul_hilo_unit
    import mul_pkg::*;
#(
    parameter int DATA_WIDTH = MUL_W_DEFAULT,
    parameter int MUL_CYCLES = MUL_CYC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op_q,
    input  logic [DATA_WIDTH-1:0] op_m,
    input  logic                  hi_wr,
    input  logic                  lo_wr,
    input  logic [DATA_WIDTH-1:0] bus_in,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
`ifdef MUL_OVF_EN
    output logic                  ovf,
`endif
    output logic                  done
);
    localparam int CNT_W = cnt_width(MUL_CYCLES);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mq_q, mq_d, mm_q, mm_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                    done_q, done_d;
    logic [2*DATA_WIDTH-1:0] prod;

    boothmul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (.q_i(mq_q), .m_i(mm_q), .p_o(prod));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mq_q    <= '0;
            mm_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mq_q    <= mq_d;
            mm_q    <= mm_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Direct writes are the default; a capture overrides them on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mq_d    = mq_q;
        mm_d    = mm_q;
        hi_d    = hi_wr ? bus_in : hi_q;
        lo_d    = lo_wr ? bus_in : lo_q;
        done_d  = 1'b0;
        if (state_q == IDLE && start) begin
            mq_d    = op_q;
            mm_d    = op_m;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
            state_d = BUSY;
        end else if (state_q == BUSY) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                {hi_d, lo_d} = prod;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
        end
    end

`ifdef MUL_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else if (state_q == BUSY && cnt_q == '0)
            ovf_q <= prod[2*DATA_WIDTH-1:DATA_WIDTH] != {DATA_WIDTH{prod[DATA_WIDTH-1]}};
    end
    assign ovf = ovf_q;
`endif

    assign in_ready = state_q == IDLE;
    assign busy     = state_q == BUSY;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule
